// File: rtl/codec_pkg.sv
// Shared constants for the I2S codec serdes: counter width, frame size and
// the counter phases at which receive/transmit events happen.
package codec_pkg;

  localparam int CNT_W      = 10;
  localparam int FRAME_BITS = 32;

  localparam logic [4:0]       RX_SMPL_PH = 5'h0F;
  localparam logic [4:0]       TX_SHFT_PH = 5'h1F;
  localparam logic [CNT_W-1:0] RX_CAPT    = 10'h010;
  localparam logic [CNT_W-1:0] TX_LOAD    = 10'h01F;
  localparam logic [CNT_W-1:0] RST_REL    = 10'h3FF;

endpackage

// File: rtl/codec_clk_gen.sv
// Codec clock and reset generator: one free-running counter whose bits are the
// codec clocks, plus the phase strobes used by the serdes datapath.
module codec_clk_gen
  import codec_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  output logic mclk,
  output logic sclk,
  output logic lrclk,
  output logic codec_rst_n,
  output logic rx_smpl,
  output logic tx_shft,
  output logic rx_capt,
  output logic tx_load
);

  logic [CNT_W-1:0] cnt;

  // codec reset releases on the first counter wrap and then stays released
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      codec_rst_n <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == RST_REL) codec_rst_n <= 1'b1;
    end
  end

  assign mclk  = cnt[1];
  assign sclk  = cnt[4];
  assign lrclk = cnt[9];

  assign rx_smpl = (cnt[4:0] == RX_SMPL_PH);
  assign tx_shft = (cnt[4:0] == TX_SHFT_PH);
  assign rx_capt = (cnt == RX_CAPT);
  assign tx_load = (cnt == TX_LOAD);

endmodule

// File: rtl/codec_serdes.sv
// I2S front/back end: drives the codec clocks and reset, deserialises SDin into
// left/right words with a valid strobe, and serialises left/right onto SDout.
module codec_serdes
  import codec_pkg::*;
#(
  parameter int SMPL_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              SDin,
  input  logic [SMPL_W-1:0] lft_tx,
  input  logic [SMPL_W-1:0] rht_tx,
  output logic              MCLK,
  output logic              SCLK,
  output logic              LRCLK,
  output logic              RSTn,
  output logic              SDout,
  output logic [SMPL_W-1:0] lft_rx,
  output logic [SMPL_W-1:0] rht_rx,
  output logic              valid
);

  logic rx_smpl;
  logic tx_shft;
  logic rx_capt;
  logic tx_load;

  logic [FRAME_BITS-1:0] shreg;
  logic [FRAME_BITS-1:0] oshreg;

  codec_clk_gen u_clk_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .mclk        (MCLK),
    .sclk        (SCLK),
    .lrclk       (LRCLK),
    .codec_rst_n (RSTn),
    .rx_smpl     (rx_smpl),
    .tx_shft     (tx_shft),
    .rx_capt     (rx_capt),
    .tx_load     (tx_load)
  );

  // the capture comes one clk after the right-channel LSB lands in shreg[0];
  // while the codec is held in reset nothing is presented downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg  <= '0;
      lft_rx <= '0;
      rht_rx <= '0;
      valid  <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rx_smpl) shreg <= {shreg[FRAME_BITS-2:0], SDin};
      if (rx_capt && RSTn) begin
        lft_rx <= shreg[FRAME_BITS-1:SMPL_W];
        rht_rx <= shreg[SMPL_W-1:0];
        valid  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oshreg <= '0;
    end else if (tx_load) begin
      oshreg <= {lft_tx, rht_tx};
    end else if (tx_shft) begin
      oshreg <= {oshreg[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign SDout = oshreg[FRAME_BITS-1];

endmodule

// File: tb/tb_codec_serdes.sv
// Bench for codec_serdes: I2S ADC/DAC models, scoreboard queues for captured
// and transmitted frames, directed frame sequences including loopback and reset.
module tb_codec_serdes;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        SDin;
  logic [15:0] lft_tx, rht_tx;
  logic        MCLK, SCLK, LRCLK, RSTn, SDout, valid;
  logic [15:0] lft_rx, rht_rx;

  int checks = 0;
  int failures = 0;

  logic [9:0]  m_cnt;
  logic        loop_en = 1'b0;
  logic        feed = 1'b1;
  logic [31:0] tb_tx = 32'h0;
  logic [31:0] adc_next = 32'h0;
  logic [31:0] adc_cur = 32'h0;
  logic [4:0]  adc_idx;
  logic        sdin_adc = 1'b0;
  logic [31:0] rx_q[$];
  logic [31:0] tx_q[$];
  logic [31:0] dac_sh = 32'h0;
  logic [31:0] prev_exp_rx = 32'h0;
  logic [31:0] rx_d = 32'h0;
  logic        valid_d = 1'b0;
  logic        rst_d = 1'b0;
  int          valid_cnt = 0;

  always #5 clk = ~clk;

  assign SDin   = loop_en ? SDout : sdin_adc;
  assign lft_tx = feed ? tb_tx[31:16] : lft_rx;
  assign rht_tx = feed ? tb_tx[15:0]  : rht_rx;

  codec_serdes dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .SDin   (SDin),
    .lft_tx (lft_tx),
    .rht_tx (rht_tx),
    .MCLK   (MCLK),
    .SCLK   (SCLK),
    .LRCLK  (LRCLK),
    .RSTn   (RSTn),
    .SDout  (SDout),
    .lft_rx (lft_rx),
    .rht_rx (rht_rx),
    .valid  (valid)
  );

  // reference frame counter: the timing the codec expects
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_cnt <= 10'h0;
    else        m_cnt <= m_cnt + 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // ADC model: slot s (cnt[9:5]) carries word bit 32-s; slot 0 carries the previous LSB
  always @(negedge clk) begin
    if (rst_n && m_cnt == 10'h020) adc_cur = adc_next;
    adc_idx  = 5'd0 - m_cnt[9:5];
    sdin_adc = adc_cur[adc_idx];
  end

  // monitor: rx scoreboard on valid, DAC reconstruction on SCLK rises
  always @(negedge clk) begin
    if (rst_n) begin
      if (valid) begin
        valid_cnt++;
        check("valid_phase", 32'(m_cnt), 32'h011);
        check("valid_rstn", 32'(RSTn), 32'h1);
        check("valid_width", 32'(valid_d), 32'h0);
        if (rx_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL valid_unexpected actual=%h required=no_valid", {lft_rx, rht_rx});
        end else begin
          check("rx_data", {lft_rx, rht_rx}, rx_q.pop_front());
        end
      end
      if (rst_d && ({lft_rx, rht_rx} != rx_d)) check("rx_change_phase", 32'(m_cnt), 32'h011);
      if (m_cnt[4:0] == 5'h10) begin
        dac_sh = {dac_sh[30:0], SDout};
        if (m_cnt == 10'h010 && tx_q.size() > 0) check("dac_data", dac_sh, tx_q.pop_front());
      end
    end
    valid_d = valid;
    rx_d    = {lft_rx, rht_rx};
    rst_d   = rst_n;
  end

  task automatic wait_cnt(input logic [9:0] t);
    int guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (m_cnt != t && guard < 2100);
    if (m_cnt != t) begin
      checks++;
      failures++;
      $display("FAIL wait_cnt actual=%h required=%h", m_cnt, t);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "frame counter never reached target");
    end
  endtask

  // releases rst_n, checks codec reset timing and clock shapes, scores frames 0 and 1
  task automatic release_and_check(input logic [31:0] adc_w, input logic [31:0] tx_w);
    int    rise1[3] = '{-1, -1, -1};
    int    rise2[3] = '{-1, -1, -1};
    int    fall1[3] = '{-1, -1, -1};
    int    per[3]   = '{4, 32, 1024};
    string nm[3]    = '{"mclk", "sclk", "lrclk"};
    logic [2:0] c;
    logic [2:0] p = 3'b000;
    int    rstn_at = -1;
    int    v_pre;
    loop_en     = 1'b0;
    feed        = 1'b1;
    adc_next    = adc_w;
    tb_tx       = tx_w;
    prev_exp_rx = adc_w;
    @(negedge clk);
    rst_n = 1'b1;
    v_pre = valid_cnt;
    for (int n = 1; n <= 1600; n++) begin
      @(negedge clk);
      c = {LRCLK, SCLK, MCLK};
      for (int i = 0; i < 3; i++) begin
        if (c[i] && !p[i]) begin
          if (rise1[i] < 0) rise1[i] = n;
          else if (rise2[i] < 0) rise2[i] = n;
        end
        if (!c[i] && p[i] && rise1[i] >= 0 && fall1[i] < 0) fall1[i] = n;
      end
      p = c;
      if (RSTn && rstn_at < 0) rstn_at = n;
      if (n == 1023) check("no_valid_in_reset", 32'(valid_cnt - v_pre), 32'h0);
      if (m_cnt == 10'h018) begin
        rx_q.push_back(adc_w);
        tx_q.push_back(tx_w);
      end
    end
    check("rstn_rise_clk", 32'(rstn_at), 32'd1024);
    for (int i = 0; i < 3; i++) begin
      check({nm[i], "_period"}, 32'(rise2[i] - rise1[i]), 32'(per[i]));
      check({nm[i], "_high"}, 32'(fall1[i] - rise1[i]), 32'(per[i] / 2));
    end
  endtask

  // issues one frame: ADC word, tx word (or rx recirculation), optional SDout->SDin loop
  task automatic do_frame(input logic [31:0] adc_w, input logic [31:0] tx_w,
                          input bit fd, input bit lp);
    logic [31:0] tx_eff;
    wait_cnt(10'h018);
    tx_eff   = fd ? tx_w : prev_exp_rx;
    adc_next = adc_w;
    tb_tx    = tx_w;
    feed     = fd;
    loop_en  = lp;
    rx_q.push_back(lp ? tx_eff : adc_w);
    tx_q.push_back(tx_eff);
    prev_exp_rx = lp ? tx_eff : adc_w;
  endtask

  initial begin
    int v0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 32'({MCLK, SCLK, LRCLK, RSTn, SDout, valid}), 32'h0);
    check("reset_rx", {lft_rx, rht_rx}, 32'h0);

    release_and_check({16'hA55A, 16'h1234}, {16'h8001, 16'h7FFE});

    v0 = valid_cnt;
    do_frame({16'hFFFF, 16'h0000}, {16'h0000, 16'hFFFF}, 1'b1, 1'b0);
    do_frame({16'h8000, 16'h0001}, {16'h7FFF, 16'hFFFE}, 1'b1, 1'b0);
    do_frame({16'hDEAD, 16'hBEEF}, {16'hCAFE, 16'hF00D}, 1'b1, 1'b0);
    do_frame({16'h0123, 16'h4567}, {16'h89AB, 16'hCDEF}, 1'b1, 1'b0);
    check("b2b_valids", 32'(valid_cnt - v0), 32'd4);

    do_frame(32'h0, 32'h0000_0000, 1'b1, 1'b1);
    do_frame(32'h0, 32'h0,         1'b0, 1'b1);
    do_frame(32'h0, 32'hFFFF_FFFF, 1'b1, 1'b1);
    do_frame(32'h0, 32'h0,         1'b0, 1'b1);
    do_frame(32'h0, 32'h8000_8000, 1'b1, 1'b1);
    do_frame(32'h0, 32'h0,         1'b0, 1'b1);
    do_frame({16'h1357, 16'h2468}, {16'h1111, 16'h2222}, 1'b1, 1'b0);

    wait_cnt(10'h150);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", 32'({MCLK, SCLK, LRCLK, RSTn, SDout, valid}), 32'h0);
    check("abort_rx", {lft_rx, rht_rx}, 32'h0);
    rx_q.delete();
    tx_q.delete();
    repeat (5) @(negedge clk);

    release_and_check({16'h5AA5, 16'hC33C}, {16'h0F0F, 16'hF0F0});
    do_frame({16'h7FFF, 16'h8000}, {16'h0001, 16'h8000}, 1'b1, 1'b0);
    wait_cnt(10'h018);
    check("rx_q_drained", 32'(rx_q.size()), 32'h0);
    check("tx_q_drained", 32'(tx_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/codec_serdes.md
Name: codec_serdes

Overview:
- I2S serial front/back end for the audio codec.
- Generates the codec clocks MCLK, SCLK and LRCLK, and the codec reset RSTn, from the system clock.
- Deserialises stereo samples from SDin into parallel left/right words with a one-cycle valid strobe. These feed the EQ engine's lft_in/rht_in/valid.
- Serialises the EQ engine's processed left/right words onto SDout.

Parameters:
- SMPL_W, 16, bits per channel. The frame is fixed at 2*SMPL_W = 32 SCLK periods; only 16 is supported.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- SDin  input  1  serial data from codec ADC
- lft_tx  input  16  processed left sample (from EQ lft_out)
- rht_tx  input  16  processed right sample (from EQ rht_out)
- MCLK  output  1  codec master clock, clk/4
- SCLK  output  1  codec bit clock, clk/32
- LRCLK  output  1  frame clock, clk/1024; low = left channel
- RSTn  output  1  codec reset, active low
- SDout  output  1  serial data to codec DAC
- lft_rx  output  16  captured left sample
- rht_rx  output  16  captured right sample
- valid  output  1  one-clk strobe, new lft_rx/rht_rx available

Behaviour:
- One clock domain. Reset is asynchronous and active-low (rst_n).
- All flops clear on rst_n low: cnt=0, shift registers=0, lft_rx=rht_rx=0, valid=0, RSTn=0. SDout therefore resets to 0.
- Reset asserted mid-frame aborts the frame immediately. No partial sample is ever presented.

Clock generation:
- cnt is a 10-bit free-running up-counter that wraps 0x3FF->0x000.
- MCLK=cnt[1], SCLK=cnt[4], LRCLK=cnt[9]. All are direct flop bits, so the outputs are glitch-free.

Codec reset:
- RSTn is registered. It is set on the clk edge where cnt==0x3FF, so it goes high 1024 clks after reset release.
- It stays high until rst_n is asserted again.

Receive:
- SDin is sampled into a 32-bit shift register (shift left, new bit into bit 0) on the edge where cnt[4:0]==0x0F, i.e. the SCLK rising edge.
- I2S one-bit delay applies: left MSB arrives on the 2nd SCLK rise after LRCLK falls. The right LSB arrives on the 1st rise of the next frame.
- On the edge where cnt==0x010: lft_rx<=shreg[31:16], rht_rx<=shreg[15:0], valid<=1 for exactly one clk.
- valid is suppressed (stays 0) while RSTn==0. The first valid therefore occurs at cnt==0x010 of the frame after RSTn rises.
- lft_rx and rht_rx hold until the next capture.

Transmit:
- A 32-bit output shift register drives SDout=oshreg[31] (registered bit, no combinational path).
- On the edge where cnt==0x01F (SCLK falling), it loads {lft_tx, rht_tx}.
- On every other edge with cnt[4:0]==0x1F, it shifts left with 0 fill.
- Load has priority over shift.
- The left MSB is therefore valid on SDout during cnt 0x020–0x03F. The right LSB is valid during cnt 0x000–0x01F of the next frame.
- lft_tx and rht_tx only need to be stable at the load edge.

Latency:
- 1 clk from the last SDin sample to valid.
- Round trip through the EQ is at least one frame.

Arithmetic:
- No arithmetic beyond the counter. Samples pass through bit-exact (two's complement, not interpreted).

Decomposition:
- Package codec_pkg holds:
  - CNT_W=10
  - compare constants RX_SMPL_PH=5'h0F, TX_SHFT_PH=5'h1F, RX_CAPT=10'h010, TX_LOAD=10'h01F, RST_REL=10'h3FF
  - FRAME_BITS=32
- Sub-module codec_clk_gen holds cnt, MCLK/SCLK/LRCLK/RSTn, and exports phase strobes rx_smpl, tx_shft, rx_capt, tx_load.
- codec_serdes holds both shift registers and the output registers.

Test Plan:
- Reset release: RSTn=0 for clks 0–1023 after rst_n rises, and 1 from clk 1024. MCLK, SCLK and LRCLK periods are 4, 32 and 1024 clks. Duty cycle is 50%.
- Receive: the codec model drives left=16'hA55A, right=16'h1234 in I2S format. At the next cnt==0x010, valid pulses 1 clk with lft_rx=16'hA55A, rht_rx=16'h1234. No valid is seen while RSTn=0.
- Transmit: lft_tx=16'h8001, rht_tx=16'h7FFE are held across the load. The DAC model, sampling on SCLK rises 1..32, reconstructs 16'h8001 and 16'h7FFE.
- Loopback: SDout is tied to SDin with the tx inputs fed from rx. Consecutive frames with values 16'h0000, 16'hFFFF, 16'h8000 reproduce the same values two frames later.
- Async reset mid-frame: rst_n is pulsed low at cnt=0x150. All outputs go to 0 immediately with no valid pulse. Recovery is identical to a cold reset.
- Back-to-back frames: 4 frames give exactly one valid per 1024 clks. Captured values change only at cnt==0x010.
